preg_free_list: RTL and testbench

PREG_FREE_LIST -- requirements
Module: preg_free_list

---
 rtl/rename_pkg.sv | 15 +
 rtl/preg_free_list.sv | 136 +++++++++++++
 tb/tb_preg_free_list.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register-file sizes, physical tag type and free-list FSM states.
package rename_pkg;

  localparam int NUM_REG_DEF   = 32;
  localparam int NUM_P_REG_DEF = 64;
  localparam int TAG_W_DEF     = $clog2(NUM_P_REG_DEF);

  typedef logic [TAG_W_DEF-1:0] preg_tag_t;

  typedef enum logic {
    FL_INIT  = 1'b0,
    FL_READY = 1'b1
  } fl_state_e;

endpackage

// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of unbound tags, filled by an init walk after reset.
// Define FREE_LIST_BYPASS_EN to let a freed tag be granted in the same cycle when the list is empty.
module preg_free_list
  import rename_pkg::*;
#(
  parameter int NUM_REG   = NUM_REG_DEF,
  parameter int NUM_P_REG = NUM_P_REG_DEF,
  localparam int TAG_W    = $clog2(NUM_P_REG),
  localparam int NUM_FREE = NUM_P_REG - NUM_REG,
  localparam int CNT_W    = $clog2(NUM_FREE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [CNT_W-1:0] free_count,
  output logic             init_done,
  output logic             overflow_err,
  output fl_state_e        dbg_state
);

  localparam int PTR_W = (NUM_FREE > 1) ? $clog2(NUM_FREE) : 1;

  // Handshake: a tag transfers on the rising edge where alloc_req && alloc_ready;
  // alloc_tag is valid (and nonzero only) while alloc_ready is high, independent of alloc_req.

  fl_state_e        state_q, state_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [TAG_W-1:0] mem_q [NUM_FREE];
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [TAG_W-1:0] mem_wdata;

  logic in_ready, list_full, list_empty;
  logic push_cand, byp, pop, push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_FREE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    in_ready   = (state_q == FL_READY);
    list_full  = (count_q == CNT_W'(NUM_FREE));
    list_empty = (count_q == '0);
    push_cand  = in_ready && free_valid && (free_tag != '0);
`ifdef FREE_LIST_BYPASS_EN
    byp        = push_cand && list_empty;
`else
    byp        = 1'b0;
`endif
    alloc_ready = (in_ready && !list_empty) || byp;
    if (byp) begin
      alloc_tag = free_tag;
    end else if (alloc_ready) begin
      alloc_tag = mem_q[head_q];
    end else begin
      alloc_tag = '0;
    end
    pop  = alloc_req && alloc_ready && !byp;
    // A bypassed tag that is taken goes straight to rename and never enters the FIFO.
    push = push_cand && !(byp && alloc_req) && (!list_full || pop);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = tail_q;
    mem_wdata = free_tag;
    case (state_q)
      FL_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = TAG_W'(NUM_REG) + TAG_W'(idx_q);
        if (idx_q == PTR_W'(NUM_FREE - 1)) begin
          state_d = FL_READY;
          head_d  = '0;
          tail_d  = '0;
          count_d = CNT_W'(NUM_FREE);
        end else begin
          idx_d = idx_q + PTR_W'(1);
        end
      end
      FL_READY: begin
        if (pop) head_d = next_ptr(head_q);
        if (push) begin
          mem_we = 1'b1;
          tail_d = next_ptr(tail_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push_cand && list_full && !pop) ovf_d = 1'b1;
      end
      default: state_d = FL_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FL_INIT;
      idx_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign free_count   = count_q;
  assign init_done    = (state_q == FL_READY);
  assign overflow_err = ovf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: queue-based reference model checked every cycle, plus directed scenarios.
module tb_preg_free_list;
  import rename_pkg::*;

  localparam int NUM_REG   = 32;
  localparam int NUM_P_REG = 64;
  localparam int TAG_W     = 6;
  localparam int NUM_FREE  = 32;
  localparam int CNT_W     = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_req = 1'b0;
  logic             free_valid = 1'b0;
  logic [TAG_W-1:0] free_tag = '0;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic [CNT_W-1:0] free_count;
  logic             init_done;
  logic             overflow_err;
  fl_state_e        dbg_state;

  int n_vec = 0;
  int n_err = 0;

  preg_free_list #(.NUM_REG(NUM_REG), .NUM_P_REG(NUM_P_REG)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .free_valid(free_valid), .free_tag(free_tag),
    .free_count(free_count), .init_done(init_done), .overflow_err(overflow_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit               m_ready;
  int               m_walk;
  logic [TAG_W-1:0] m_q[$];
  bit               m_ovf;

  function automatic bit m_bypass();
`ifdef FREE_LIST_BYPASS_EN
    return m_ready && (m_q.size() == 0) && free_valid && (free_tag != 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    bit pop;
    bit pushc;
    int sz;
    if (rst) begin
      m_ready = 1'b0;
      m_walk  = 0;
      m_q.delete();
      m_ovf   = 1'b0;
    end else if (!m_ready) begin
      m_walk++;
      if (m_walk == NUM_FREE) begin
        m_ready = 1'b1;
        for (int i = 0; i < NUM_FREE; i++) m_q.push_back(TAG_W'(NUM_REG + i));
      end
    end else begin
      sz    = m_q.size();
      pushc = free_valid && (free_tag != 0);
      if (m_bypass()) begin
        if (!alloc_req) m_q.push_back(free_tag);
      end else begin
        pop = alloc_req && (sz != 0);
        if (pop) void'(m_q.pop_front());
        if (pushc) begin
          if (sz == NUM_FREE && !pop) m_ovf = 1'b1;
          else m_q.push_back(free_tag);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic             exp_ready;
    logic [TAG_W-1:0] exp_tag;
    if (m_bypass()) begin
      exp_ready = 1'b1;
      exp_tag   = free_tag;
    end else if (m_ready && m_q.size() != 0) begin
      exp_ready = 1'b1;
      exp_tag   = m_q[0];
    end else begin
      exp_ready = 1'b0;
      exp_tag   = '0;
    end
    check("model_alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    check("model_alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    check("model_free_count", 32'(free_count), 32'(m_q.size()));
    check("model_init_done", 32'(init_done), 32'(m_ready));
    check("model_overflow_err", 32'(overflow_err), 32'(m_ovf));
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic free_one(input logic [TAG_W-1:0] t);
    free_valid = 1'b1;
    free_tag   = t;
    tick();
    free_valid = 1'b0;
    free_tag   = '0;
  endtask

  initial begin
    logic [TAG_W-1:0] small_tags[5] = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd8};
    logic [TAG_W-1:0] drain_tags[5] = '{6'd4, 6'd5, 6'd6, 6'd8, 6'd7};

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_alloc_ready", 32'(alloc_ready), 0);
    check("rst_alloc_tag", 32'(alloc_tag), 0);
    check("rst_free_count", 32'(free_count), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_overflow", 32'(overflow_err), 0);

    // init walk: done after exactly 32 edges
    rst = 1'b0;
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd9;
    repeat (31) tick();
    check("init_31_done", 32'(init_done), 0);
    check("init_31_ready", 32'(alloc_ready), 0);
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = '0;
    tick();
    check("init_32_done", 32'(init_done), 1);
    check("init_32_count", 32'(free_count), 32);
    check("init_32_tag", 32'(alloc_tag), 32);

    // drain all 32 tags in order
    alloc_req = 1'b1;
    for (int i = 0; i < NUM_FREE; i++) begin
      #1;
      check("drain_tag", 32'(alloc_tag), 32'(32 + i));
      tick();
    end
    check("drain_empty_ready", 32'(alloc_ready), 0);
    check("drain_empty_count", 32'(free_count), 0);
    check("drain_empty_tag", 32'(alloc_tag), 0);

    // empty list, free 45 with alloc_req
    free_valid = 1'b1;
    free_tag   = 6'd45;
    #1;
`ifdef FREE_LIST_BYPASS_EN
    check("empty_byp_ready", 32'(alloc_ready), 1);
    check("empty_byp_tag", 32'(alloc_tag), 45);
`else
    check("empty_nobyp_ready", 32'(alloc_ready), 0);
    check("empty_nobyp_tag", 32'(alloc_tag), 0);
`endif
    tick();
    free_valid = 1'b0;
    free_tag   = '0;
    #1;
`ifdef FREE_LIST_BYPASS_EN
    check("empty_byp_count", 32'(free_count), 0);
    check("empty_byp_after", 32'(alloc_ready), 0);
`else
    check("empty_next_ready", 32'(alloc_ready), 1);
    check("empty_next_tag", 32'(alloc_tag), 45);
    check("empty_next_count", 32'(free_count), 1);
`endif
    tick();
    alloc_req = 1'b0;
    check("empty_final_count", 32'(free_count), 0);

    // tag 0 is never pushed
    free_one(6'd0);
    check("p0_count", 32'(free_count), 0);
    check("p0_ready", 32'(alloc_ready), 0);

    // count 5, simultaneous alloc + free 7
    foreach (small_tags[i]) free_one(small_tags[i]);
    check("five_count", 32'(free_count), 5);
    check("five_tag", 32'(alloc_tag), 3);
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_tag   = 6'd7;
    #1;
    check("simul_grant", 32'(alloc_tag), 3);
    tick();
    free_valid = 1'b0;
    free_tag   = '0;
    check("simul_count", 32'(free_count), 5);
    foreach (drain_tags[i]) begin
      #1;
      check("order_tag", 32'(alloc_tag), 32'(drain_tags[i]));
      tick();
    end
    alloc_req = 1'b0;
    check("order_count", 32'(free_count), 0);

    // fill to full, then full-list corner cases
    for (int i = 0; i < NUM_FREE; i++) free_one(TAG_W'(32 + i));
    check("full_count", 32'(free_count), 32);
    check("full_tag", 32'(alloc_tag), 32);
    alloc_req = 1'b1;
    free_one(6'd50);
    alloc_req = 1'b0;
    check("full_swap_count", 32'(free_count), 32);
    check("full_swap_ovf", 32'(overflow_err), 0);
    check("full_swap_tag", 32'(alloc_tag), 33);
    free_one(6'd40);
    check("ovf_set", 32'(overflow_err), 1);
    check("ovf_count", 32'(free_count), 32);
    check("ovf_tag", 32'(alloc_tag), 33);
    free_one(6'd0);
    check("ovf_p0_count", 32'(free_count), 32);
    check("ovf_sticky", 32'(overflow_err), 1);
    tick();
    check("ovf_sticky2", 32'(overflow_err), 1);

    // reset in the middle of the init walk
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("midwalk_done", 32'(init_done), 0);
    rst = 1'b1;
    #1;
    check("rerst_count", 32'(free_count), 0);
    check("rerst_ovf", 32'(overflow_err), 0);
    tick();
    rst = 1'b0;
    repeat (31) tick();
    check("rewalk_31_done", 32'(init_done), 0);
    tick();
    check("rewalk_32_done", 32'(init_done), 1);
    check("rewalk_count", 32'(free_count), 32);
    check("rewalk_tag", 32'(alloc_tag), 32);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
